tdc_sweep_ctrl: RTL and testbench

- On-chip measurement sequencer that drives the TDC stimulus pins and collects its Hamming-weight result.
- Drives launch edge, capture edge and pulse-gen controls (clk_launch, clk_capture, pg_src, pg_bypass, pg_in, pg_tog) with a programmable coarse launch-to-capture delay.
- Reads back hw after synchronizer settling, repeats for a programmed sample count, and reports min/max/sum.
- Replaces manual ui_in toggling for characterization sweeps.

---
 rtl/tdc_sweep_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_tdc_sweep_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_sweep_ctrl.sv
// tdc_sweep_ctrl
// ----------------------------------------------------------------------------
// Measurement sequencer for the on-chip TDC. Each run issues a programmable
// number of launch/capture strobe pairs with a coarse launch-to-capture gap.
// After each capture it waits for the TDC synchronizer to settle, reads the
// Hamming-weight result and folds it into min/max/saturating-sum statistics.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, abort               run control (start only sampled in IDLE)
//   cfg_delay, cfg_samples     WAIT cycles per sample, samples per run
//   cfg_src, cfg_bypass        pulse-gen static controls used during a run
//   hw                         TDC Hamming-weight result
//   clk_launch, clk_capture    TDC strobes
//   pg_src, pg_bypass          pulse-gen static controls (0 while idle)
//   pg_in, pg_tog              pulse-gen input (launch timing) and toggle
//   busy, done                 run in progress, one-cycle completion pulse
//   hw_min, hw_max, hw_sum     per-run statistics
//   sample_cnt                 samples accumulated so far
//
// Every output is a register. A state's actions are written on the clock
// edge that ends that state, so an output belonging to state X becomes
// visible in the cycle after X.
// ----------------------------------------------------------------------------
module tdc_sweep_ctrl #(
  parameter int N_O    = 6,
  parameter int CNT_W  = 8,
  parameter int ACC_W  = 16,
  parameter int N_SYNC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_samples,
  input  logic             cfg_src,
  input  logic             cfg_bypass,
  input  logic [N_O:0]     hw,
  output logic             clk_launch,
  output logic             clk_capture,
  output logic             pg_src,
  output logic             pg_bypass,
  output logic             pg_in,
  output logic             pg_tog,
  output logic             busy,
  output logic             done,
  output logic [N_O:0]     hw_min,
  output logic [N_O:0]     hw_max,
  output logic [ACC_W-1:0] hw_sum,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_SETTLE  = 3'd4;
  localparam logic [2:0] S_ACCUM   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // SETTLE counts down from this value to zero inclusive: N_SYNC+2 cycles.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(N_SYNC + 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] delay_q;
  logic [CNT_W-1:0] samples_q;
  logic             src_q;
  logic             bypass_q;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_sat;
  logic [CNT_W-1:0] cnt_inc;

  // One extra bit catches the carry so the sum clamps instead of wrapping.
  always_comb begin
    sum_wide = {1'b0, hw_sum} + {{(ACC_W - N_O){1'b0}}, hw};
    sum_sat  = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
    cnt_inc  = sample_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      delay_q     <= '0;
      samples_q   <= '0;
      src_q       <= 1'b0;
      bypass_q    <= 1'b0;
      cnt         <= '0;
      clk_launch  <= 1'b0;
      clk_capture <= 1'b0;
      pg_src      <= 1'b0;
      pg_bypass   <= 1'b0;
      pg_in       <= 1'b0;
      pg_tog      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hw_min      <= '1;
      hw_max      <= '0;
      hw_sum      <= '0;
      sample_cnt  <= '0;
    end else if (abort && (state != S_IDLE)) begin
      // Abort wins over every transition; statistics are left as they are.
      state       <= S_IDLE;
      clk_launch  <= 1'b0;
      clk_capture <= 1'b0;
      pg_in       <= 1'b0;
      pg_src      <= 1'b0;
      pg_bypass   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort is tested here too so start+abort together is ignored.
          if (start && !abort) begin
            delay_q    <= cfg_delay;
            samples_q  <= cfg_samples;
            src_q      <= cfg_src;
            bypass_q   <= cfg_bypass;
            pg_src     <= cfg_src;
            pg_bypass  <= cfg_bypass;
            busy       <= 1'b1;
            hw_min     <= '1;
            hw_max     <= '0;
            hw_sum     <= '0;
            sample_cnt <= '0;
            state      <= (cfg_samples == '0) ? S_DONE : S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          clk_launch  <= 1'b1;
          pg_in       <= 1'b1;
          pg_tog      <= ~pg_tog;
          clk_capture <= 1'b0;
          cnt         <= delay_q;
          state       <= (delay_q != '0) ? S_WAIT : S_CAPTURE;
        end

        S_WAIT: begin
          clk_launch  <= 1'b0;
          pg_in       <= 1'b0;
          clk_capture <= 1'b0;
          cnt         <= cnt - CNT_W'(1);
          // cnt entered WAIT at delay_q (>0); the last WAIT cycle sees 1.
          if (cnt <= CNT_W'(1)) begin
            state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          clk_launch  <= 1'b0;
          pg_in       <= 1'b0;
          clk_capture <= 1'b1;
          cnt         <= SETTLE_LOAD;
          state       <= S_SETTLE;
        end

        S_SETTLE: begin
          clk_launch  <= 1'b0;
          pg_in       <= 1'b0;
          clk_capture <= 1'b0;
          if (cnt == '0) begin
            state <= S_ACCUM;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_ACCUM: begin
          if (hw < hw_min) begin
            hw_min <= hw;
          end
          if (hw > hw_max) begin
            hw_max <= hw;
          end
          hw_sum     <= sum_sat;
          sample_cnt <= cnt_inc;
          state      <= (cnt_inc == samples_q) ? S_DONE : S_LAUNCH;
        end

        S_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          pg_src    <= 1'b0;
          pg_bypass <= 1'b0;
          state     <= S_IDLE;
        end

        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          clk_launch  <= 1'b0;
          clk_capture <= 1'b0;
          pg_in       <= 1'b0;
          pg_src      <= src_q & 1'b0;
          pg_bypass   <= bypass_q & 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_sweep_ctrl.sv
// tb_tdc_sweep_ctrl
// ----------------------------------------------------------------------------
// Table-driven bench for tdc_sweep_ctrl. Each table row is one complete run
// with hand-computed statistics and strobe timing. A second instance with an
// 8-bit accumulator shares the stimulus to exercise sum saturation. Abort,
// IDLE-abort and asynchronous reset are covered by hand-written sequences.
// ----------------------------------------------------------------------------
module tb_tdc_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_delay = '0;
  logic [7:0] cfg_samples = '0;
  logic       cfg_src = 1'b0;
  logic       cfg_bypass = 1'b0;
  logic [6:0] hw = '0;

  logic        clk_launch, clk_capture, pg_src, pg_bypass, pg_in, pg_tog;
  logic        busy, done;
  logic [6:0]  hw_min, hw_max;
  logic [15:0] hw_sum;
  logic [7:0]  sample_cnt;

  logic        clk_launch8, clk_capture8, pg_src8, pg_bypass8, pg_in8, pg_tog8;
  logic        busy8, done8;
  logic [6:0]  hw_min8, hw_max8;
  logic [7:0]  hw_sum8;
  logic [7:0]  sample_cnt8;

  int total = 0;
  int bad = 0;

  tdc_sweep_ctrl #(.N_O(6), .CNT_W(8), .ACC_W(16), .N_SYNC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_delay(cfg_delay), .cfg_samples(cfg_samples),
    .cfg_src(cfg_src), .cfg_bypass(cfg_bypass), .hw(hw),
    .clk_launch(clk_launch), .clk_capture(clk_capture),
    .pg_src(pg_src), .pg_bypass(pg_bypass), .pg_in(pg_in), .pg_tog(pg_tog),
    .busy(busy), .done(done), .hw_min(hw_min), .hw_max(hw_max),
    .hw_sum(hw_sum), .sample_cnt(sample_cnt)
  );

  tdc_sweep_ctrl #(.N_O(6), .CNT_W(8), .ACC_W(8), .N_SYNC(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_delay(cfg_delay), .cfg_samples(cfg_samples),
    .cfg_src(cfg_src), .cfg_bypass(cfg_bypass), .hw(hw),
    .clk_launch(clk_launch8), .clk_capture(clk_capture8),
    .pg_src(pg_src8), .pg_bypass(pg_bypass8), .pg_in(pg_in8), .pg_tog(pg_tog8),
    .busy(busy8), .done(done8), .hw_min(hw_min8), .hw_max(hw_max8),
    .hw_sum(hw_sum8), .sample_cnt(sample_cnt8)
  );

  always #5 clk = ~clk;

  typedef struct {
    int delay;
    int samples;
    int src;
    int bypass;
    int hw0, hw1, hw2, hw3;
    int exp_min, exp_max, exp_sum, exp_sum8, exp_cnt;
    int exp_launches, exp_gap, exp_period, exp_busy;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] pickHw(input vec_t v, input int k);
    case (k % 4)
      0:       return 7'(v.hw0);
      1:       return 7'(v.hw1);
      2:       return 7'(v.hw2);
      default: return 7'(v.hw3);
    endcase
  endfunction

  // Runs one table row from IDLE to the done pulse and checks it.
  task automatic applyStimulus(input vec_t v, input int idx);
    int   launches = 0;
    int   captures = 0;
    int   toggles = 0;
    int   busy_cycles = 0;
    int   first_launch = -1;
    int   second_launch = -1;
    int   first_capture = -1;
    bit   finished = 0;
    logic prev_l, prev_c, prev_t;
    string tag;
    tag = $sformatf("v%0d", idx);

    hw          = pickHw(v, 0);
    cfg_delay   = 8'(v.delay);
    cfg_samples = 8'(v.samples);
    cfg_src     = (v.src != 0);
    cfg_bypass  = (v.bypass != 0);
    prev_l = clk_launch;
    prev_c = clk_capture;
    prev_t = pg_tog;
    start  = 1'b1;
    tick();
    start = 1'b0;
    // Configuration changes while busy must not affect the run.
    cfg_delay   = 8'd7;
    cfg_samples = 8'd2;
    cfg_src     = (v.src == 0);
    cfg_bypass  = (v.bypass == 0);
    checkOutput({tag, "_pg_src_run"}, int'(pg_src), v.src);
    checkOutput({tag, "_pg_bypass_run"}, int'(pg_bypass), v.bypass);

    for (int c = 0; c < 400 && !finished; c++) begin
      start = (c == 2 && v.samples != 0);
      if (clk_launch && !prev_l) begin
        if (first_launch < 0) first_launch = c;
        else if (second_launch < 0) second_launch = c;
        launches++;
      end
      if (clk_capture && !prev_c) begin
        if (first_capture < 0) first_capture = c;
        hw = pickHw(v, captures);
        captures++;
      end
      if (pg_tog != prev_t) toggles++;
      if (busy) busy_cycles++;
      if (done) begin
        finished = 1;
        checkOutput({tag, "_busy_at_done"}, int'(busy), 0);
        checkOutput({tag, "_pg_src_done"}, int'(pg_src), 0);
      end
      prev_l = clk_launch;
      prev_c = clk_capture;
      prev_t = pg_tog;
      if (!finished) tick();
    end
    start = 1'b0;

    checkOutput({tag, "_done_seen"}, int'(finished), 1);
    checkOutput({tag, "_hw_min"}, int'(hw_min), v.exp_min);
    checkOutput({tag, "_hw_max"}, int'(hw_max), v.exp_max);
    checkOutput({tag, "_hw_sum"}, int'(hw_sum), v.exp_sum);
    checkOutput({tag, "_sample_cnt"}, int'(sample_cnt), v.exp_cnt);
    checkOutput({tag, "_hw_sum8"}, int'(hw_sum8), v.exp_sum8);
    checkOutput({tag, "_sample_cnt8"}, int'(sample_cnt8), v.exp_cnt);
    checkOutput({tag, "_launches"}, launches, v.exp_launches);
    checkOutput({tag, "_tog_changes"}, toggles, v.exp_launches);
    checkOutput({tag, "_busy_cycles"}, busy_cycles, v.exp_busy);
    if (v.exp_launches > 0)
      checkOutput({tag, "_launch_to_capture"}, first_capture - first_launch, v.exp_gap);
    if (v.exp_launches > 1)
      checkOutput({tag, "_sample_period"}, second_launch - first_launch, v.exp_period);

    tick();
    checkOutput({tag, "_done_one_cycle"}, int'(done), 0);
    checkOutput({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int launches;
    int dones;
    logic prev_l;

    //          dly smp src byp hw0 hw1 hw2 hw3 min max sum  sum8 cnt  L gap per busy
    vecs[0] = '{3,  1,  1,  0,  20, 20, 20, 20, 20, 20, 20,  20,  1,  1, 4,  9,  10};
    vecs[1] = '{0,  4,  0,  1,  10, 30, 5,  64, 5,  64, 109, 109, 4,  4, 1,  6,  25};
    vecs[2] = '{0,  0,  1,  1,  33, 33, 33, 33, 127, 0, 0,   0,   0,  0, 0,  0,  1};
    vecs[3] = '{2,  3,  1,  0,  0,  64, 33, 0,  0,  64, 97,  97,  3,  3, 3,  8,  25};
    vecs[4] = '{1,  10, 0,  0,  64, 64, 64, 64, 64, 64, 640, 255, 10, 10, 2, 7,  71};

    // Reset state
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_hw_min", int'(hw_min), 127);
    checkOutput("rst_hw_max", int'(hw_max), 0);
    checkOutput("rst_hw_sum", int'(hw_sum), 0);
    checkOutput("rst_sample_cnt", int'(sample_cnt), 0);
    checkOutput("rst_launch", int'(clk_launch), 0);
    checkOutput("rst_pg_tog", int'(pg_tog), 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Abort during the third WAIT of a 5-sample run
    hw = 7'd9;
    cfg_delay = 8'd2;
    cfg_samples = 8'd5;
    cfg_src = 1'b1;
    cfg_bypass = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    launches = 0;
    prev_l = clk_launch;
    for (int c = 0; c < 100 && launches < 3; c++) begin
      if (clk_launch && !prev_l) launches++;
      prev_l = clk_launch;
      if (launches < 3) tick();
    end
    checkOutput("abort_third_launch_seen", launches, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_launch", int'(clk_launch), 0);
    checkOutput("abort_capture", int'(clk_capture), 0);
    checkOutput("abort_pg_src", int'(pg_src), 0);
    checkOutput("abort_sample_cnt", int'(sample_cnt), 2);
    checkOutput("abort_hw_sum", int'(hw_sum), 18);
    dones = 0;
    launches = 0;
    prev_l = clk_launch;
    for (int c = 0; c < 30; c++) begin
      if (done) dones++;
      if (clk_launch && !prev_l) launches++;
      prev_l = clk_launch;
      tick();
    end
    checkOutput("abort_no_done", dones, 0);
    checkOutput("abort_no_launch", launches, 0);
    checkOutput("abort_held_cnt", int'(sample_cnt), 2);

    // start and abort together in IDLE: nothing happens
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("idle_abort_busy", int'(busy), 0);
    tick();
    checkOutput("idle_abort_launch", int'(clk_launch), 0);

    // A new run is accepted after the abort
    applyStimulus(vecs[1], 5);

    // Asynchronous reset right after the second capture strobe
    hw = 7'd40;
    cfg_delay = 8'd3;
    cfg_samples = 8'd2;
    cfg_src = 1'b1;
    cfg_bypass = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    launches = 0;
    prev_l = clk_capture;
    for (int c = 0; c < 100 && launches < 2; c++) begin
      if (clk_capture && !prev_l) launches++;
      prev_l = clk_capture;
      if (launches < 2) tick();
    end
    checkOutput("rstmid_capture_seen", launches, 2);
    checkOutput("rstmid_hw_max_before", int'(hw_max), 40);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_capture", int'(clk_capture), 0);
    checkOutput("rstmid_busy", int'(busy), 0);
    checkOutput("rstmid_pg_src", int'(pg_src), 0);
    checkOutput("rstmid_hw_min", int'(hw_min), 127);
    checkOutput("rstmid_hw_max", int'(hw_max), 0);
    checkOutput("rstmid_hw_sum", int'(hw_sum), 0);
    checkOutput("rstmid_sample_cnt", int'(sample_cnt), 0);
    #1;
    rst_n = 1'b1;
    tick();
    checkOutput("rstmid_idle_after", int'(busy), 0);

    applyStimulus(vecs[0], 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
